// File: rtl/mtr_pkg.sv
// Shared constants and types for the motor PWM measurement block.
package mtr_pkg;

  // Duty width; the PWM period is 2^PWM_W clocks and must match the motor driver.
  localparam int unsigned PWM_W = 11;
  localparam logic [PWM_W-1:0] PWM_MAX = 11'h7FF;

  typedef logic [PWM_W-1:0] spd_t;

endpackage

// File: rtl/mtr_pwm_meas_if.sv
// Pin-pair inputs and measurement results of mtr_pwm_meas.
// The slave modport is the measurement block; the master side drives the PWM pins.
interface mtr_pwm_meas_if #(
  parameter int unsigned PWM_W = mtr_pkg::PWM_W
) ();

  logic             PWM_frwrd_lft;
  logic             PWM_rev_lft;
  logic             PWM_frwrd_rght;
  logic             PWM_rev_rght;
  logic [PWM_W-1:0] lft_spd;
  logic             lft_rev;
  logic [PWM_W-1:0] rght_spd;
  logic             rght_rev;
  logic             meas_vld;
  logic [1:0]       shoot_thru;

  modport master (
    output PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght,
    input  lft_spd, lft_rev, rght_spd, rght_rev, meas_vld, shoot_thru
  );

  modport slave (
    input  PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght,
    output lft_spd, lft_rev, rght_spd, rght_rev, meas_vld, shoot_thru
  );

endinterface

// File: rtl/pwm_chan_meas.sv
// One wheel side: integrates forward/reverse pin high-time over a window and
// latches magnitude, direction and shoot-through at the window end strobe.
module pwm_chan_meas import mtr_pkg::*; #(
  parameter int unsigned PWM_W = mtr_pkg::PWM_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frwrd_i,
  input  logic             rev_i,
  input  logic             win_end_i,
  output logic [PWM_W-1:0] spd_o,
  output logic             rev_o,
  output logic             shoot_o
);

  // One extra bit: a window that is high every cycle counts to 2^PWM_W.
  logic [PWM_W:0]   f_acc_q, f_acc_d;
  logic [PWM_W:0]   r_acc_q, r_acc_d;
  logic [PWM_W:0]   f_tot, r_tot, big;
  logic             st_q, st_d, st_tot;
  logic [PWM_W-1:0] spd_q, spd_d;
  logic             rev_q, rev_d;
  logic             shoot_q, shoot_d;

  // Accumulate this cycle's sample; on the terminal cycle fold it into the result and clear.
  always_comb begin
    f_tot   = f_acc_q + {{PWM_W{1'b0}}, frwrd_i};
    r_tot   = r_acc_q + {{PWM_W{1'b0}}, rev_i};
    st_tot  = st_q | (frwrd_i & rev_i);
    big     = (r_tot > f_tot) ? r_tot : f_tot;
    f_acc_d = f_tot;
    r_acc_d = r_tot;
    st_d    = st_tot;
    spd_d   = spd_q;
    rev_d   = rev_q;
    shoot_d = shoot_q;
    if (win_end_i) begin
      f_acc_d = '0;
      r_acc_d = '0;
      st_d    = 1'b0;
      spd_d   = big[PWM_W] ? {PWM_W{1'b1}} : big[PWM_W-1:0];
      // A tie (including an idle window) keeps the last known direction.
      if (r_tot > f_tot) begin
        rev_d = 1'b1;
      end else if (f_tot > r_tot) begin
        rev_d = 1'b0;
      end
      shoot_d = st_tot;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_acc_q <= '0;
      r_acc_q <= '0;
      st_q    <= 1'b0;
      spd_q   <= '0;
      rev_q   <= 1'b0;
      shoot_q <= 1'b0;
    end else begin
      f_acc_q <= f_acc_d;
      r_acc_q <= r_acc_d;
      st_q    <= st_d;
      spd_q   <= spd_d;
      rev_q   <= rev_d;
      shoot_q <= shoot_d;
    end
  end

  assign spd_o   = spd_q;
  assign rev_o   = rev_q;
  assign shoot_o = shoot_q;

endmodule

// File: rtl/mtr_pwm_meas.sv
// Motor PWM measurement monitor: recovers per-wheel speed and direction from
// the forward/reverse PWM pin pairs over free-running 2^PWM_W-clock windows.
// Optional macro MTR_PWM_SYNC_EN inserts 2-flop synchronizers on the PWM pins.
module mtr_pwm_meas import mtr_pkg::*; #(
  parameter int unsigned PWM_W = mtr_pkg::PWM_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mtr_pwm_meas_if.slave bus
);

  logic [PWM_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_end;
  logic             meas_vld_q, meas_vld_d;
  logic [3:0]       pins_raw, pins;
  logic [PWM_W-1:0] lft_spd, rght_spd;
  logic             lft_rev, rght_rev, lft_st, rght_st;

  // {rev_rght, frwrd_rght, rev_lft, frwrd_lft}
  assign pins_raw = {bus.PWM_rev_rght, bus.PWM_frwrd_rght, bus.PWM_rev_lft, bus.PWM_frwrd_lft};

`ifdef MTR_PWM_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  // Two-stage synchronizer for asynchronous external pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pins = sync2_q;
`else
  assign pins = pins_raw;
`endif

  // Window is free-running; a full-period integral does not depend on driver phase.
  always_comb begin
    win_end    = &win_cnt_q;
    win_cnt_d  = win_cnt_q + 1'b1;
    meas_vld_d = win_end;
  end

  // Window counter and result-valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      meas_vld_q <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      meas_vld_q <= meas_vld_d;
    end
  end

  pwm_chan_meas #(
    .PWM_W (PWM_W)
  ) u_lft (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .frwrd_i   (pins[0]),
    .rev_i     (pins[1]),
    .win_end_i (win_end),
    .spd_o     (lft_spd),
    .rev_o     (lft_rev),
    .shoot_o   (lft_st)
  );

  pwm_chan_meas #(
    .PWM_W (PWM_W)
  ) u_rght (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .frwrd_i   (pins[2]),
    .rev_i     (pins[3]),
    .win_end_i (win_end),
    .spd_o     (rght_spd),
    .rev_o     (rght_rev),
    .shoot_o   (rght_st)
  );

  assign bus.lft_spd    = lft_spd;
  assign bus.lft_rev    = lft_rev;
  assign bus.rght_spd   = rght_spd;
  assign bus.rght_rev   = rght_rev;
  assign bus.meas_vld   = meas_vld_q;
  assign bus.shoot_thru = {rght_st, lft_st};

endmodule

// File: tb/tb_mtr_pwm_meas.sv
// Directed bench for mtr_pwm_meas: table of steady PWM patterns plus
// hand-written mixed-direction, shoot-through and mid-window reset sequences.
module tb_mtr_pwm_meas;
  import mtr_pkg::*;

  localparam int WIN = 2048;

  typedef struct {
    int         fl_d, fl_p, rl_d, rl_p, fr_d, fr_p, rr_d, rr_p;
    int         nwin;
    logic [10:0] e_lspd;
    logic        e_lrev;
    logic [10:0] e_rspd;
    logic        e_rrev;
    logic [1:0]  e_st;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mtr_pwm_meas_if #(.PWM_W(PWM_W)) bus ();

  mtr_pwm_meas #(.PWM_W(PWM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pat(input int i, input int d, input int p);
    return ((i + p) % WIN) < d;
  endfunction

  // Present one cycle of pins (at +2 after an edge) and advance to +2 after the next edge.
  task automatic drive_cycle(input logic fl, input logic rl, input logic fr, input logic rr);
    bus.PWM_frwrd_lft  = fl;
    bus.PWM_rev_lft    = rl;
    bus.PWM_frwrd_rght = fr;
    bus.PWM_rev_rght   = rr;
    @(posedge clk);
    #2;
  endtask

  task automatic end_window(input string name, input int extra);
    chk({name, " vld_at_end"}, {31'd0, bus.meas_vld}, 32'd1);
    chk({name, " vld_midwin"}, extra, 0);
  endtask

  task automatic check_outs(input string name, input logic [10:0] lspd, input logic lrev,
                            input logic [10:0] rspd, input logic rrev, input logic [1:0] st);
    chk({name, " lft_spd"}, {21'd0, bus.lft_spd}, {21'd0, lspd});
    chk({name, " lft_rev"}, {31'd0, bus.lft_rev}, {31'd0, lrev});
    chk({name, " rght_spd"}, {21'd0, bus.rght_spd}, {21'd0, rspd});
    chk({name, " rght_rev"}, {31'd0, bus.rght_rev}, {31'd0, rrev});
    chk({name, " shoot_thru"}, {30'd0, bus.shoot_thru}, {30'd0, st});
  endtask

  task automatic run_vec(input vec_t v, input string name);
    for (int w = 0; w < v.nwin; w++) begin
      int extra = 0;
      for (int i = 0; i < WIN; i++) begin
        drive_cycle(pat(i, v.fl_d, v.fl_p), pat(i, v.rl_d, v.rl_p),
                    pat(i, v.fr_d, v.fr_p), pat(i, v.rr_d, v.rr_p));
        if (i < WIN - 1 && bus.meas_vld) extra++;
      end
      end_window($sformatf("%s w%0d", name, w), extra);
    end
    check_outs(name, v.e_lspd, v.e_lrev, v.e_rspd, v.e_rrev, v.e_st);
  endtask

  vec_t vecs[7];

  initial begin
    int extra;
    vec_t rv;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 11'h000, 1'b0, 11'h000, 1'b0, 2'b00};
    vecs[1] = '{1024, 0, 0, 0, 1024, 777, 0, 0, 2, 11'h400, 1'b0, 11'h400, 1'b0, 2'b00};
    vecs[2] = '{0, 0, 1024, 333, 2047, 5, 0, 0, 2, 11'h400, 1'b1, 11'h7FF, 1'b0, 2'b00};
    vecs[3] = '{0, 0, 1024, 333, 2048, 0, 0, 0, 2, 11'h400, 1'b1, 11'h7FF, 1'b0, 2'b00};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 5, 10, 2, 11'h000, 1'b1, 11'h005, 1'b1, 2'b00};
    vecs[5] = '{1, 0, 0, 0, 100, 0, 100, 1000, 2, 11'h001, 1'b0, 11'h064, 1'b1, 2'b00};
    vecs[6] = '{300, 0, 600, 1000, 0, 0, 0, 0, 2, 11'h258, 1'b1, 11'h000, 1'b1, 2'b00};

    bus.PWM_frwrd_lft  = 1'b0;
    bus.PWM_rev_lft    = 1'b0;
    bus.PWM_frwrd_rght = 1'b0;
    bus.PWM_rev_rght   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset meas_vld", {31'd0, bus.meas_vld}, 32'd0);
    check_outs("reset", 11'h000, 1'b0, 11'h000, 1'b0, 2'b00);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Mixed window: forward 0x200 in first half, reverse 0x180 in second half.
    extra = 0;
    for (int i = 0; i < WIN; i++) begin
      drive_cycle((i < 1024) && (i < 'h200), (i >= 1024) && (i - 1024 < 'h180), 1'b0, 1'b0);
      if (i < WIN - 1 && bus.meas_vld) extra++;
    end
    end_window("mixed", extra);
    check_outs("mixed", 11'h200, 1'b0, 11'h000, 1'b1, 2'b00);

    rv = '{0, 0, 'h300, 0, 0, 0, 0, 0, 1, 11'h300, 1'b1, 11'h000, 1'b1, 2'b00};
    run_vec(rv, "after_mixed");

    // Single-cycle overlap on the left pair.
    extra = 0;
    for (int i = 0; i < WIN; i++) begin
      drive_cycle(i == 100, i == 100, 1'b0, 1'b0);
      if (i < WIN - 1 && bus.meas_vld) extra++;
    end
    end_window("shoot", extra);
    check_outs("shoot", 11'h001, 1'b1, 11'h000, 1'b1, 2'b01);

    rv = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 11'h000, 1'b1, 11'h000, 1'b1, 2'b00};
    run_vec(rv, "shoot_clear");

    // Mid-window reset with 0x400 forward drive on the left.
    rv = '{1024, 1500, 0, 0, 0, 0, 0, 0, 2, 11'h400, 1'b0, 11'h000, 1'b1, 2'b00};
    run_vec(rv, "pre_reset");
    for (int i = 0; i < 500; i++) drive_cycle(pat(i, 1024, 1500), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 11'h000, 1'b0, 11'h000, 1'b0, 2'b00);
    chk("async_reset meas_vld", {31'd0, bus.meas_vld}, 32'd0);
    #1;
    for (int i = 0; i < 4; i++) drive_cycle(pat(i, 1024, 1500), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    rv = '{1024, 1500, 0, 0, 0, 0, 0, 0, 1, 11'h400, 1'b0, 11'h000, 1'b0, 2'b00};
    run_vec(rv, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
